// File: rtl/lfsr_hex_display_if.sv
// ---------------------------------------------------------------------------
// lfsr_hex_display_if
//
// Bundles the control inputs and the observable outputs of lfsr_hex_display.
//
//   Parameter
//     WIDTH       LFSR width in bits (multiple of 4, 8..32)
//
//   Signals
//     load        load seed this cycle
//     seed        value to load (zero is replaced by 1)
//     run         level: 1 = free-run, 0 = stopped
//     step        single-step request (rising edge honoured while stopped)
//     lfsr_q      current LFSR state
//     seed_fix    one-cycle pulse when a zero seed was replaced by 1
//     period      measured sequence period (0 when measurement is disabled)
//     period_vld  period holds a valid measurement
//     hout        7 segments per hex digit, digit k on hout[7k+6:7k]
//
//   Modports
//     master      drives the controls, observes the outputs
//     slave       the LFSR/display block itself
// ---------------------------------------------------------------------------
interface lfsr_hex_display_if #(
    parameter int WIDTH = 8
);
    localparam int DIGITS = WIDTH / 4;

    logic                  load;
    logic [WIDTH-1:0]      seed;
    logic                  run;
    logic                  step;
    logic [WIDTH-1:0]      lfsr_q;
    logic                  seed_fix;
    logic [WIDTH-1:0]      period;
    logic                  period_vld;
    logic [7*DIGITS-1:0]   hout;

    modport master (
        output load, seed, run, step,
        input  lfsr_q, seed_fix, period, period_vld, hout
    );

    modport slave (
        input  load, seed, run, step,
        output lfsr_q, seed_fix, period, period_vld, hout
    );
endinterface

// File: rtl/lfsr_hex_display.sv
// ---------------------------------------------------------------------------
// lfsr_hex_display
//
// Fibonacci-style LFSR pseudo-random source with a multi-digit seven-segment
// hex readout. The register shifts left and inserts the XOR of the tapped
// bits at bit 0. It can free-run through a prescaler, single-step on a
// rising edge of step, or be loaded with a seed. A zero seed (the lock-up
// state) is replaced by 1 and flagged with a one-cycle seed_fix pulse.
//
//   Parameters
//     WIDTH           LFSR width, multiple of 4, 8..32 (WIDTH/4 digits)
//     TAPS            feedback mask, bit i set = q[i] takes part in the XOR
//     RESET_SEED      LFSR value after reset, must be nonzero
//     DIV             clocks per shift while running, 1..65536
//     SEG_ACTIVE_LOW  1 = a segment is lit by a 0
//
//   Ports
//     clk             clock, all state on the rising edge
//     rst             asynchronous reset, active low
//     bus             lfsr_hex_display_if.slave (controls in, state/display out)
//
//   Optional build macro
//     LFSR_PERIOD_EN  when defined, a saturating shift counter measures the
//                     number of shifts taken to return to the loaded value
//                     (or RESET_SEED if nothing was loaded since reset) and
//                     reports it on period/period_vld. When undefined, period
//                     and period_vld are tied to 0.
// ---------------------------------------------------------------------------
module lfsr_hex_display #(
    parameter int               WIDTH          = 8,
    parameter logic [WIDTH-1:0] TAPS           = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] RESET_SEED     = WIDTH'(1),
    parameter int               DIV            = 4,
    parameter bit               SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    lfsr_hex_display_if.slave   bus
);

    localparam int DIGITS = WIDTH / 4;
    localparam int HW     = 7 * DIGITS;

    // Prescaler is wide enough to hold DIV-1; DIV=1 still needs one bit.
    localparam int             PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(DIV - 1);

    // Display value while in reset: every segment dark.
    localparam logic [HW-1:0]  HOUT_OFF = {HW{SEG_ACTIVE_LOW}};

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], ^(v & TAPS)};
    endfunction

    // Active-high pattern a..g on bits 0..6, inverted for active-low panels.
    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return SEG_ACTIVE_LOW ? ~seg : seg;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [PW-1:0]     pre_q, pre_d;
    logic              step_dly_q, step_dly_d;
    logic [WIDTH-1:0]  lfsr_q, lfsr_d;
    logic              seed_fix_q, seed_fix_d;
    logic [HW-1:0]     hout_q, hout_d;

    logic [WIDTH-1:0]  load_val;
    logic              run_tick;
    logic              step_evt;
    logic              shift_en;

    // -----------------------------------------------------------------------
    // Control FSM, prescaler, step edge detect and the LFSR itself
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        step_dly_d = bus.step;
        lfsr_d     = lfsr_q;
        seed_fix_d = 1'b0;
        run_tick   = 1'b0;

        // Zero would lock the register forever, so it is swapped for 1.
        load_val = (bus.seed == '0) ? WIDTH'(1) : bus.seed;

        case (state_q)
            ST_STOP: begin
                if (bus.run) begin
                    state_d = ST_RUN;
                    pre_d   = '0;
                end
            end
            ST_RUN: begin
                // The shift decision uses the current state, so the edge that
                // leaves RUN can still carry a due shift.
                if (!bus.run) begin
                    state_d = ST_STOP;
                end
                if (pre_q == PRE_LAST) begin
                    pre_d    = '0;
                    run_tick = 1'b1;
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
            default: begin
                state_d = ST_STOP;
            end
        endcase

        // Only a fresh rising edge counts, so a held step gives one shift.
        step_evt = (state_q == ST_STOP) && bus.step && !step_dly_q;
        shift_en = !bus.load && (run_tick || step_evt);

        if (bus.load) begin
            lfsr_d     = load_val;
            seed_fix_d = (bus.seed == '0);
            pre_d      = '0;
            step_dly_d = 1'b0;
        end else if (shift_en) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    // Display is a registered copy of the current LFSR value.
    always_comb begin
        hout_d = '0;
        for (int k = 0; k < DIGITS; k++) begin
            hout_d[7*k +: 7] = hex_seg(lfsr_q[4*k +: 4]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_STOP;
            pre_q      <= '0;
            step_dly_q <= 1'b0;
            lfsr_q     <= RESET_SEED;
            seed_fix_q <= 1'b0;
            hout_q     <= HOUT_OFF;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            step_dly_q <= step_dly_d;
            lfsr_q     <= lfsr_d;
            seed_fix_q <= seed_fix_d;
            hout_q     <= hout_d;
        end
    end

    assign bus.lfsr_q   = lfsr_q;
    assign bus.seed_fix = seed_fix_q;
    assign bus.hout     = hout_q;

    // -----------------------------------------------------------------------
    // Optional period measurement
    // -----------------------------------------------------------------------
`ifdef LFSR_PERIOD_EN
    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == '1) ? v : v + WIDTH'(1);
    endfunction

    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  ref_q, ref_d;
    logic [WIDTH-1:0]  period_q, period_d;
    logic              period_vld_q, period_vld_d;

    always_comb begin
        cnt_d        = cnt_q;
        ref_d        = ref_q;
        period_d     = period_q;
        period_vld_d = period_vld_q;

        if (bus.load) begin
            cnt_d        = '0;
            ref_d        = load_val;
            period_d     = '0;
            period_vld_d = 1'b0;
        end else if (shift_en) begin
            // The counter keeps running past a return, so every later
            // return re-latches the (possibly saturated) count.
            cnt_d = sat_inc(cnt_q);
            if (lfsr_d == ref_q) begin
                period_d     = cnt_d;
                period_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            ref_q        <= RESET_SEED;
            period_q     <= '0;
            period_vld_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            ref_q        <= ref_d;
            period_q     <= period_d;
            period_vld_q <= period_vld_d;
        end
    end

    assign bus.period     = period_q;
    assign bus.period_vld = period_vld_q;
`else
    assign bus.period     = '0;
    assign bus.period_vld = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_hex_display.sv
`timescale 1ns/1ps
module tb_lfsr_hex_display;

    localparam int             W      = 8;
    localparam int             D      = W / 4;
    localparam logic [W-1:0]   TAPS_T = 8'hB8;
    localparam logic [W-1:0]   SEED0  = 8'h01;
    localparam int             DIVV   = 4;
    localparam longint         MAXV   = (64'd1 << W) - 1;
`ifdef LFSR_PERIOD_EN
    localparam bit PER_EN = 1'b1;
`else
    localparam bit PER_EN = 1'b0;
`endif

    // Segment patterns a..g (bit0..6), active high, for hex 0..F.
    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lfsr_hex_display_if #(.WIDTH(W)) bus ();
    lfsr_hex_display_if #(.WIDTH(W)) bus1 ();

    // Second instance (DIV=1) sees the same stimulus.
    assign bus1.load = bus.load;
    assign bus1.seed = bus.seed;
    assign bus1.run  = bus.run;
    assign bus1.step = bus.step;

    lfsr_hex_display #(.WIDTH(W), .TAPS(TAPS_T), .RESET_SEED(SEED0), .DIV(DIVV),
                       .SEG_ACTIVE_LOW(1'b1))
        dut (.clk(clk), .rst(rst), .bus(bus));

    lfsr_hex_display #(.WIDTH(W), .TAPS(TAPS_T), .RESET_SEED(SEED0), .DIV(1),
                       .SEG_ACTIVE_LOW(1'b1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (for dut)
    logic [W-1:0]     m_q, m_ref, m_per;
    logic             m_fix, m_vld, m_run, m_sd;
    int               m_since;   // RUN edges since entry or load
    longint           m_cnt;     // shifts since load/reset
    logic [7*D-1:0]   m_hout;

    function automatic logic [W-1:0] adv(input logic [W-1:0] v);
        int ones;
        ones = $countones(v & TAPS_T);
        return (v << 1) | W'(ones % 2);
    endfunction

    function automatic logic [7*D-1:0] show(input logic [W-1:0] v);
        logic [7*D-1:0] r;
        logic [3:0]     nib;
        r = '0;
        for (int k = 0; k < D; k++) begin
            nib = 4'(v >> (4*k));
            r[7*k +: 7] = ~SEG_TAB[nib];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_q = SEED0; m_ref = SEED0; m_per = '0; m_fix = 0; m_vld = 0;
        m_run = 0; m_sd = 0; m_since = 0; m_cnt = 0; m_hout = '1;
    endtask

    // Advance model by one edge using the inputs now applied, then wait for
    // that edge and settle 1 ns past it.
    task automatic cycle();
        logic [W-1:0]   nq, nref, nper;
        logic           nfix, nsd, nrun, nvld;
        int             nsince;
        longint         ncnt;
        logic [7*D-1:0] nh;
        nh = show(m_q); nq = m_q; nfix = 0; nsd = bus.step; nrun = m_run;
        nsince = m_since; ncnt = m_cnt; nref = m_ref; nper = m_per; nvld = m_vld;
        if (m_run) nsince = m_since + 1;
        if (bus.load) begin
            nq = (bus.seed == '0) ? W'(1) : bus.seed;
            nfix = (bus.seed == '0); nsd = 0; nsince = 0;
            nref = nq; ncnt = 0; nper = '0; nvld = 0;
        end else if ((m_run && (nsince % DIVV == 0)) || (!m_run && bus.step && !m_sd)) begin
            nq = adv(m_q);
            ncnt = m_cnt + 1;
            if (nq == m_ref) begin
                nper = (ncnt > MAXV) ? W'(MAXV) : W'(ncnt);
                nvld = 1;
            end
        end
        if (!m_run && bus.run) begin nrun = 1; nsince = 0; end
        else if (m_run && !bus.run) nrun = 0;
        @(posedge clk); #1;
        m_q = nq; m_ref = nref; m_per = nper; m_fix = nfix; m_vld = nvld;
        m_run = nrun; m_sd = nsd; m_since = nsince; m_cnt = ncnt; m_hout = nh;
    endtask

    task automatic test_reset();
        bus.load = 0; bus.seed = '0; bus.run = 0; bus.step = 0;
        #2 rst = 1'b0;
        model_reset();
        #1;
        n_tests++; if (bus.lfsr_q !== 8'h01) begin n_fail++; $display("FAIL reset_q got=%h exp=%h", bus.lfsr_q, 8'h01); end
        n_tests++; if (bus.hout !== 14'h3FFF) begin n_fail++; $display("FAIL reset_hout got=%h exp=%h", bus.hout, 14'h3FFF); end
        n_tests++; if (bus.seed_fix !== 1'b0) begin n_fail++; $display("FAIL reset_fix got=%b exp=0", bus.seed_fix); end
        n_tests++; if (bus.period_vld !== 1'b0 || bus.period !== '0) begin n_fail++; $display("FAIL reset_period got=%h/%b exp=0/0", bus.period, bus.period_vld); end
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (bus.hout !== 14'h3FFF) begin n_fail++; $display("FAIL reset_hold_hout got=%h exp=%h", bus.hout, 14'h3FFF); end
        rst = 1'b1;
        cycle();
        n_tests++; if (bus.hout !== 14'h2079) begin n_fail++; $display("FAIL reset_first_hout got=%h exp=%h", bus.hout, 14'h2079); end
        n_tests++; if (bus.lfsr_q !== 8'h01) begin n_fail++; $display("FAIL reset_after_q got=%h exp=%h", bus.lfsr_q, 8'h01); end
    endtask

    task automatic test_load_step();
        bus.load = 1; bus.seed = 8'h80;
        cycle();
        bus.load = 0;
        n_tests++; if (bus.lfsr_q !== 8'h80) begin n_fail++; $display("FAIL load_q got=%h exp=%h", bus.lfsr_q, 8'h80); end
        n_tests++; if (bus.hout !== m_hout) begin n_fail++; $display("FAIL load_hout_lag got=%h exp=%h", bus.hout, m_hout); end
        cycle();
        n_tests++; if (bus.hout !== show(8'h80)) begin n_fail++; $display("FAIL load_hout got=%h exp=%h", bus.hout, show(8'h80)); end
        bus.step = 1;
        cycle();
        n_tests++; if (bus.lfsr_q !== 8'h01) begin n_fail++; $display("FAIL step1_q got=%h exp=%h", bus.lfsr_q, 8'h01); end
        bus.step = 0;
        cycle();
        n_tests++; if (bus.lfsr_q !== 8'h01) begin n_fail++; $display("FAIL step1_idle_q got=%h exp=%h", bus.lfsr_q, 8'h01); end
        bus.step = 1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_tests++; if (bus.lfsr_q !== 8'h02) begin n_fail++; $display("FAIL step_hold_q[%0d] got=%h exp=%h", i, bus.lfsr_q, 8'h02); end
        end
        bus.step = 0;
        cycle();
    endtask

    task automatic test_zero_seed();
        bus.load = 1; bus.seed = '0;
        cycle();
        bus.load = 0;
        n_tests++; if (bus.lfsr_q !== 8'h01) begin n_fail++; $display("FAIL zero_q got=%h exp=%h", bus.lfsr_q, 8'h01); end
        n_tests++; if (bus.seed_fix !== 1'b1) begin n_fail++; $display("FAIL zero_fix_hi got=%b exp=1", bus.seed_fix); end
        cycle();
        n_tests++; if (bus.seed_fix !== 1'b0) begin n_fail++; $display("FAIL zero_fix_lo got=%b exp=0", bus.seed_fix); end
        bus.load = 1; bus.seed = 8'h5A;
        cycle();
        bus.load = 0;
        n_tests++; if (bus.seed_fix !== 1'b0 || bus.lfsr_q !== 8'h5A) begin n_fail++; $display("FAIL nz_load got=%h/%b exp=5a/0", bus.lfsr_q, bus.seed_fix); end
    endtask

    task automatic test_run();
        logic [W-1:0] e;
        bus.load = 1; bus.seed = 8'hB8;
        cycle();
        bus.load = 0; bus.run = 1;
        cycle();
        for (int k = 1; k <= 4; k++) begin
            cycle();
            e = (k < 4) ? 8'hB8 : 8'h70;
            n_tests++; if (bus.lfsr_q !== e) begin n_fail++; $display("FAIL run_div_q[%0d] got=%h exp=%h", k, bus.lfsr_q, e); end
        end
        for (int i = 0; i < 12; i++) begin
            bus.step = 1'(i % 2);
            cycle();
            n_tests++; if (bus.lfsr_q !== m_q) begin n_fail++; $display("FAIL run_step_q[%0d] got=%h exp=%h", i, bus.lfsr_q, m_q); end
        end
        bus.step = 0; bus.run = 0;
        cycle();
        cycle();
        n_tests++; if (bus.lfsr_q !== m_q) begin n_fail++; $display("FAIL run_stop_q got=%h exp=%h", bus.lfsr_q, m_q); end
    endtask

    task automatic test_div1_period();
        logic [W-1:0] e1;
        bus.load = 1; bus.seed = 8'h01; bus.run = 0; bus.step = 0;
        cycle();
        bus.load = 0; bus.run = 1;
        cycle();
        e1 = 8'h01;
        for (int i = 1; i <= 255; i++) begin
            cycle();
            e1 = adv(e1);
            n_tests++; if (bus1.lfsr_q !== e1) begin n_fail++; $display("FAIL div1_q[%0d] got=%h exp=%h", i, bus1.lfsr_q, e1); end
            if (i == 254) begin
                n_tests++; if (bus1.period_vld !== 1'b0) begin n_fail++; $display("FAIL period_early got=%b exp=0", bus1.period_vld); end
            end
        end
        n_tests++; if (bus1.period_vld !== PER_EN) begin n_fail++; $display("FAIL period_vld got=%b exp=%b", bus1.period_vld, PER_EN); end
        n_tests++; if (bus1.period !== (PER_EN ? 8'd255 : 8'd0)) begin n_fail++; $display("FAIL period_val got=%0d exp=%0d", bus1.period, PER_EN ? 255 : 0); end
        n_tests++; if (bus.period !== (PER_EN ? m_per : 8'd0) || bus.period_vld !== (PER_EN ? m_vld : 1'b0)) begin n_fail++; $display("FAIL period_main got=%h/%b exp=%h/%b", bus.period, bus.period_vld, PER_EN ? m_per : 8'd0, PER_EN ? m_vld : 1'b0); end
        bus.run = 0;
        cycle();
        bus.load = 1; bus.seed = 8'h33;
        cycle();
        bus.load = 0;
        n_tests++; if (bus1.period_vld !== 1'b0 || bus1.period !== '0) begin n_fail++; $display("FAIL period_reload got=%h/%b exp=0/0", bus1.period, bus1.period_vld); end
    endtask

    task automatic test_random();
        logic [W-1:0] ep;
        logic         ev;
        bus.run = 0; bus.step = 0; bus.load = 0;
        for (int i = 0; i < 400; i++) begin
            bus.load = ($urandom % 24 == 0);
            bus.seed = ($urandom % 4 == 0) ? '0 : W'($urandom);
            if ($urandom % 20 == 0) bus.run = ~bus.run;
            bus.step = ($urandom % 3 == 0);
            cycle();
            ep = PER_EN ? m_per : '0;
            ev = PER_EN ? m_vld : 1'b0;
            n_tests++; if (bus.lfsr_q !== m_q) begin n_fail++; $display("FAIL rnd_q[%0d] got=%h exp=%h", i, bus.lfsr_q, m_q); end
            n_tests++; if (bus.seed_fix !== m_fix) begin n_fail++; $display("FAIL rnd_fix[%0d] got=%b exp=%b", i, bus.seed_fix, m_fix); end
            n_tests++; if (bus.hout !== m_hout) begin n_fail++; $display("FAIL rnd_hout[%0d] got=%h exp=%h", i, bus.hout, m_hout); end
            n_tests++; if (bus.period !== ep || bus.period_vld !== ev) begin n_fail++; $display("FAIL rnd_period[%0d] got=%h/%b exp=%h/%b", i, bus.period, bus.period_vld, ep, ev); end
        end
        bus.load = 0; bus.step = 0; bus.run = 0;
        cycle();
    endtask

    task automatic test_reset_midrun();
        bus.run = 1; bus.load = 0; bus.step = 0;
        repeat (6) cycle();
        bus.load = 1; bus.seed = 8'hC3;
        #2 rst = 1'b0;
        #1;
        model_reset();
        n_tests++; if (bus.lfsr_q !== SEED0 || bus1.lfsr_q !== SEED0) begin n_fail++; $display("FAIL midrst_q got=%h/%h exp=%h", bus.lfsr_q, bus1.lfsr_q, SEED0); end
        n_tests++; if (bus.period_vld !== 1'b0 || bus.hout !== 14'h3FFF) begin n_fail++; $display("FAIL midrst_misc got=%b/%h exp=0/3fff", bus.period_vld, bus.hout); end
        @(posedge clk); #1;
        n_tests++; if (bus.lfsr_q !== SEED0) begin n_fail++; $display("FAIL midrst_hold_q got=%h exp=%h", bus.lfsr_q, SEED0); end
        rst = 1'b1; bus.load = 0; bus.run = 0; bus.step = 1;
        cycle();
        n_tests++; if (bus.lfsr_q !== 8'h02) begin n_fail++; $display("FAIL midrst_stop_step got=%h exp=%h", bus.lfsr_q, 8'h02); end
        bus.step = 0;
        cycle();
        n_tests++; if (bus.lfsr_q !== m_q || bus.hout !== m_hout) begin n_fail++; $display("FAIL midrst_after got=%h/%h exp=%h/%h", bus.lfsr_q, bus.hout, m_q, m_hout); end
    endtask

    initial begin
        test_reset();
        test_load_step();
        test_zero_seed();
        test_run();
        test_div1_period();
        test_random();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
